// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed 4-digit display scanner with a freeze/hold register.
//
// Each digit is dark for BLANK_CYC cycles, then lit for DIV cycles. The digit index
// then advances modulo 4. frame_done marks the first cycle of a new frame, that is,
// the cycle in which digit has just wrapped from 3 to 0. Dropping enable returns the
// scanner to an idle, blanked digit 0.
// A rising edge on freeze captures t_bcd into t_hold and raises stop. A falling edge
// on freeze clears stop. This logic runs independently of the scan state.
//
// Ports:
//   clk         system clock, rising-edge
//   reset_n     asynchronous active-low reset
//   enable      scan enable (level)
//   t_bcd       live time value, three BCD nibbles
//   freeze      freeze request (level)
//   digit       index of the digit being driven, 0..3
//   blank       all digit enables off while high
//   stop        display shows t_hold instead of t_bcd while high
//   t_hold      time value captured on the freeze rising edge
//   frame_done  one-cycle pulse marking the digit 3 -> 0 wrap
module display_scan_ctrl #(
  parameter int unsigned DIV       = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [11:0] t_bcd,
  input  logic        freeze,
  output logic [1:0]  digit,
  output logic        blank,
  output logic        stop,
  output logic [11:0] t_hold,
  output logic        frame_done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBlank = 2'd1;
  localparam logic [1:0] StOn    = 2'd2;

  localparam logic [15:0] DivLast   = 16'(DIV - 1);
  localparam logic [15:0] BlankLast = (BLANK_CYC == 0) ? 16'd0 : 16'(BLANK_CYC - 1);
  // With no blanking interval, the scanner moves from one lit interval directly to the next.
  localparam logic [1:0]  StLit     = (BLANK_CYC == 0) ? StOn : StBlank;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  digit_q, digit_d;
  logic        frame_done_q, frame_done_d;
  logic        freeze_q;
  logic        stop_q;
  logic [11:0] t_hold_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    digit_d      = digit_q;
    frame_done_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StLit;
          cnt_d   = 16'd0;
          digit_d = 2'd0;
        end
      end
      StBlank: begin
        if (!enable) begin
          state_d = StIdle;
          cnt_d   = 16'd0;
          digit_d = 2'd0;
        end else if (cnt_q == BlankLast) begin
          state_d = StOn;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StOn: begin
        if (!enable) begin
          // Abort takes priority, so no frame_done pulse on the wrap cycle.
          state_d = StIdle;
          cnt_d   = 16'd0;
          digit_d = 2'd0;
        end else if (cnt_q == DivLast) begin
          state_d      = StLit;
          cnt_d        = 16'd0;
          digit_d      = digit_q + 2'd1;
          frame_done_d = (digit_q == 2'd3);
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 16'd0;
        digit_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= 16'd0;
      digit_q      <= 2'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      freeze_q <= 1'b0;
      stop_q   <= 1'b0;
      t_hold_q <= 12'h000;
    end else begin
      freeze_q <= freeze;
      if (freeze && !freeze_q) begin
        stop_q   <= 1'b1;
        t_hold_q <= t_bcd;
      end else if (!freeze && freeze_q) begin
        stop_q <= 1'b0;
      end
    end
  end

  assign digit      = digit_q;
  assign blank      = (state_q != StOn);
  assign frame_done = frame_done_q;
  assign stop       = stop_q;
  assign t_hold     = t_hold_q;

endmodule
